// File: rtl/pwm_duty_decoder_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder_if
//   Groups the PWM sample input and the duty readback outputs of the
//   pwm_duty_decoder into one bundle.
//
//   Signals:
//     pwm_in      : asynchronous PWM waveform being measured
//     duty        : last computed duty, floor(high*256/period)
//     duty_valid  : one-cycle pulse when duty updates
//     high_cnt    : latched high time of the last complete period
//     period_cnt  : latched period, rising edge to rising edge
//     overrun     : sticky, a period completed while the divider was busy
//     signal_lost : no rising edge seen within the timeout
//
//   Modports:
//     master : the side that supplies pwm_in and consumes the readback
//     slave  : the decoder itself
// ---------------------------------------------------------------------------
interface pwm_duty_decoder_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [7:0]       duty;
  logic             duty_valid;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             overrun;
  logic             signal_lost;

  modport master (
    output pwm_in,
    input  duty, duty_valid, high_cnt, period_cnt, overrun, signal_lost
  );

  modport slave (
    input  pwm_in,
    output duty, duty_valid, high_cnt, period_cnt, overrun, signal_lost
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//   Receive-side PWM measurement. Synchronises one PWM waveform, measures
//   its high time and period (rising edge to rising edge) in clock cycles,
//   then divides with an 8-step shift-subtract divider to produce an 8-bit
//   duty value floor(high*256/period). A period counter that saturates in
//   MEASURE flags loss of signal.
//
//   Ports:
//     clk_in : system clock
//     rst_in : asynchronous active-high reset, clears all state
//     bus    : pwm_duty_decoder_if.slave (pwm_in in; duty, duty_valid,
//              high_cnt, period_cnt, overrun, signal_lost out)
//
//   Parameters:
//     CNT_W       : width of high-time / period counters; the timeout
//                   threshold is 2^CNT_W-1 cycles
//     SYNC_STAGES : input synchronizer depth, at least 2
//
//   Optional build macro:
//     PWM_DECODE_GLITCH_FILTER_EN : adds a 3-cycle stability filter after
//     the synchronizer. Both edges gain the same fixed delay, so measured
//     widths are unchanged; pulses of 1-2 cycles are suppressed.
// ---------------------------------------------------------------------------
module pwm_duty_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  pwm_duty_decoder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones; saturation is the timeout.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_raw;
  logic                   pwm_s;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
    end
  end

  assign pwm_raw = sync_q[SYNC_STAGES-1];

`ifdef PWM_DECODE_GLITCH_FILTER_EN
  // ---------------------------------------------------------------------
  // Stability filter: the filtered level follows the synchronized level
  // only once it has disagreed for 3 consecutive cycles.
  // ---------------------------------------------------------------------
  logic       filt_q;
  logic [1:0] stab_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else if (pwm_raw == filt_q) begin
      stab_q <= 2'd0;
    end else if (stab_q == 2'd2) begin
      filt_q <= pwm_raw;
      stab_q <= 2'd0;
    end else begin
      stab_q <= stab_q + 2'd1;
    end
  end

  assign pwm_s = filt_q;
`else
  assign pwm_s = pwm_raw;
`endif

  // ---------------------------------------------------------------------
  // Edge detect
  // ---------------------------------------------------------------------
  logic pwm_d_q;
  logic rise;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pwm_d_q <= 1'b0;
    end else begin
      pwm_d_q <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d_q;

  // ---------------------------------------------------------------------
  // Measurement FSM and divider
  // ---------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] per_run_q,    per_run_d;
  logic [CNT_W-1:0] high_run_q,   high_run_d;
  logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] div_per_q,    div_per_d;
  logic [CNT_W:0]   rem_q,        rem_d;
  logic [7:0]       quo_q,        quo_d;
  logic [3:0]       iter_q,       iter_d;
  logic [7:0]       duty_q,       duty_d;
  logic             duty_valid_q, duty_valid_d;
  logic             overrun_q,    overrun_d;
  logic             lost_q,       lost_d;

  logic [CNT_W:0]   rem_shift;
  logic             div_ge;
  logic [CNT_W:0]   rem_next;

  // One restoring-division step. rem < period <= 2^CNT_W-1 always, so the
  // shifted value fits in CNT_W+1 bits and the dropped MSB is always zero.
  assign rem_shift = rem_q << 1;
  assign div_ge    = (rem_shift >= {1'b0, div_per_q});
  assign rem_next  = div_ge ? (rem_shift - {1'b0, div_per_q}) : rem_shift;

  always_comb begin
    state_d      = state_q;
    per_run_d    = per_run_q;
    high_run_d   = high_run_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    div_per_d    = div_per_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    iter_d       = iter_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    overrun_d    = overrun_q;
    lost_d       = lost_q;

    // Run counters keep measuring through DIVIDE. Gating the high counter
    // on pwm_s freezes it from the falling edge until the next restart.
    if (state_q != IDLE) begin
      per_run_d = sat_inc(per_run_q);
      if (pwm_s) begin
        high_run_d = sat_inc(high_run_q);
      end
    end

    unique case (state_q)
      IDLE: begin
        // First edge only arms the measurement; nothing is reported.
        if (rise) begin
          per_run_d  = CNT_ONE;
          high_run_d = CNT_ONE;
          lost_d     = 1'b0;
          state_d    = MEASURE;
        end
      end

      MEASURE: begin
        // Rise is checked before saturation so a coincident edge still
        // produces a measurement from the saturated count.
        if (rise) begin
          high_cnt_d   = high_run_q;
          period_cnt_d = per_run_q;
          div_per_d    = per_run_q;
          rem_d        = {1'b0, high_run_q};
          quo_d        = 8'd0;
          iter_d       = 4'd0;
          per_run_d    = CNT_ONE;
          high_run_d   = CNT_ONE;
          state_d      = DIVIDE;
        end else if (per_run_q == CNT_MAX) begin
          duty_d       = pwm_s ? 8'hFF : 8'h00;
          duty_valid_d = 1'b1;
          lost_d       = 1'b1;
          state_d      = IDLE;
        end
      end

      DIVIDE: begin
        // A period ending while busy is dropped; the running division is
        // left to complete.
        if (rise) begin
          overrun_d  = 1'b1;
          per_run_d  = CNT_ONE;
          high_run_d = CNT_ONE;
        end
        if (iter_q == 4'd8) begin
          duty_d       = quo_q;
          duty_valid_d = 1'b1;
          state_d      = MEASURE;
        end else begin
          rem_d  = rem_next;
          quo_d  = {quo_q[6:0], div_ge};
          iter_d = iter_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      per_run_q    <= '0;
      high_run_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      div_per_q    <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      iter_q       <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_run_q    <= per_run_d;
      high_run_q   <= high_run_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      div_per_q    <= div_per_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      iter_q       <= iter_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      overrun_q    <= overrun_d;
      lost_q       <= lost_d;
    end
  end

  assign bus.duty        = duty_q;
  assign bus.duty_valid  = duty_valid_q;
  assign bus.high_cnt    = high_cnt_q;
  assign bus.period_cnt  = period_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
module tb_pwm_duty_decoder;

  localparam int SYNC = 2;
`ifdef PWM_DECODE_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = SYNC + 13;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = SYNC + 10;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_duty_decoder_if #(.CNT_W(16)) bus16 ();
  pwm_duty_decoder_if #(.CNT_W(8))  bus8 ();

  pwm_duty_decoder #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus16)
  );
  pwm_duty_decoder #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk_in(clk), .rst_in(rst), .bus(bus8)
  );

  typedef struct {
    int duty;
    int high;
    int period;
    int cyc;
    bit sl;
  } ev_t;

  typedef struct {
    int high;
    int period;
    int nper;
    int exp_duty;
    int exp_cnt;
    bit exp_ovr;
  } vec_t;

  ev_t  obs[$];
  ev_t  obs8[$];
  ev_t  exp_q[$];
  bit   lv[$];
  int   rise_cyc[$];
  bit   exp_ovr;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl[5];

  always @(negedge clk) begin
    if (!rst && bus16.duty_valid)
      obs.push_back('{int'(bus16.duty), int'(bus16.high_cnt), int'(bus16.period_cnt), cyc, bus16.signal_lost});
    if (!rst && bus8.duty_valid)
      obs8.push_back('{int'(bus8.duty), int'(bus8.high_cnt), int'(bus8.period_cnt), cyc, bus8.signal_lost});
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input bit v);
    bus16.pwm_in = v;
    lv.push_back(v);
    @(negedge clk);
  endtask

  task automatic tick8(input bit v);
    bus8.pwm_in = v;
    @(negedge clk);
  endtask

  task automatic drive_period(input int high, input int period, input int glitch_at);
    rise_cyc.push_back(cyc);
    for (int i = 0; i < period; i++)
      tick((i < high) && !(glitch_at >= 0 && (i == glitch_at || i == glitch_at + 1)));
  endtask

  task automatic start_scn();
    bus16.pwm_in = 1'b0;
    bus8.pwm_in  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs.delete();
    obs8.delete();
    lv.delete();
    rise_cyc.delete();
    @(negedge clk);
  endtask

  // Reference: find rising edges in the (optionally filtered) level stream,
  // measure each rise-to-rise interval, and drop any rise arriving fewer
  // than 10 cycles after the last accepted one.
  task automatic run_model();
    bit s[$];
    bit prev = 1'b0;
    bit cur;
    int start = -1;
    int acc = -1000;
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < lv.size(); i++) begin
      if (FILT) cur = (i >= 2 && lv[i] == lv[i-1] && lv[i] == lv[i-2]) ? lv[i] : prev;
      else      cur = lv[i];
      s.push_back(cur);
      if (cur && !prev) begin
        if (start >= 0) begin
          if (i - acc < 10) begin
            exp_ovr = 1'b1;
          end else begin
            int h = 0;
            for (int j = start; j < i; j++) h += int'(s[j]);
            exp_q.push_back('{h * 256 / (i - start), h, i - start, 0, 1'b0});
            acc = i;
          end
        end
        start = i;
      end
      prev = cur;
    end
  endtask

  task automatic compare_model(input string tag);
    run_model();
    check({tag, " count"}, obs.size(), exp_q.size());
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
      check({tag, " duty"},   obs[k].duty,   exp_q[k].duty);
      check({tag, " high"},   obs[k].high,   exp_q[k].high);
      check({tag, " period"}, obs[k].period, exp_q[k].period);
    end
    check({tag, " overrun"}, int'(bus16.overrun), int'(exp_ovr));
  endtask

  initial begin
    rst = 1'b1;
    bus16.pwm_in = 1'b0;
    bus8.pwm_in  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst duty",        int'(bus16.duty),        0);
    check("rst duty_valid",  int'(bus16.duty_valid),  0);
    check("rst high_cnt",    int'(bus16.high_cnt),    0);
    check("rst period_cnt",  int'(bus16.period_cnt),  0);
    check("rst overrun",     int'(bus16.overrun),     0);
    check("rst signal_lost", int'(bus16.signal_lost), 0);

    // Table-driven steady patterns
    tbl[0] = '{64,  256, 4, 64,  3, 1'b0};
    tbl[1] = '{128, 200, 3, 163, 2, 1'b0};
    tbl[2] = '{1,   200, 3, 1,   2, 1'b0};
    tbl[3] = '{199, 200, 3, 254, 2, 1'b0};
    tbl[4] = '{3,   6,   4, 128, 2, 1'b1};
    for (int t = 0; t < 5; t++) begin
      start_scn();
      for (int p = 0; p < tbl[t].nper; p++) drive_period(tbl[t].high, tbl[t].period, -1);
      repeat (25) tick(1'b0);
      check("tbl count", obs.size(), tbl[t].exp_cnt);
      for (int k = 0; k < obs.size(); k++) begin
        check("tbl duty",   obs[k].duty,   tbl[t].exp_duty);
        check("tbl high",   obs[k].high,   tbl[t].high);
        check("tbl period", obs[k].period, tbl[t].period);
      end
      if (obs.size() > 0) check("tbl latency", obs[0].cyc - rise_cyc[1], LAT);
      check("tbl overrun", int'(bus16.overrun), int'(tbl[t].exp_ovr));
      repeat (30) tick(1'b0);
      check("tbl overrun sticky", int'(bus16.overrun), int'(tbl[t].exp_ovr));
    end

    // Randomized periods against the reference model
    for (int r = 0; r < 6; r++) begin
      int np;
      start_scn();
      np = $urandom_range(5, 3);
      for (int p = 0; p < np; p++) begin
        int per, hi;
        per = $urandom_range(300, 10);
        hi  = $urandom_range(per - 3, 3);
        drive_period(hi, per, -1);
      end
      repeat (25) tick(1'b0);
      compare_model("rand");
    end

    // Short low glitches inside the high phase
    start_scn();
    for (int p = 0; p < 4; p++) drive_period(64, 256, 20);
    repeat (25) tick(1'b0);
    compare_model("glitch");

    // Reset while dividing
    start_scn();
    drive_period(64, 256, -1);
    repeat (5) tick(1'b1);
    check("mid high_cnt before", int'(bus16.high_cnt), 64);
    bus16.pwm_in = 1'b0;
    rst = 1'b1;
    #1;
    check("mid duty",        int'(bus16.duty),        0);
    check("mid duty_valid",  int'(bus16.duty_valid),  0);
    check("mid high_cnt",    int'(bus16.high_cnt),    0);
    check("mid period_cnt",  int'(bus16.period_cnt),  0);
    check("mid overrun",     int'(bus16.overrun),     0);
    check("mid signal_lost", int'(bus16.signal_lost), 0);
    @(negedge clk);
    rst = 1'b0;
    lv.delete();
    obs.delete();
    repeat (20) tick(1'b0);
    check("mid no valid", obs.size(), 0);
    for (int p = 0; p < 2; p++) drive_period(64, 256, -1);
    repeat (25) tick(1'b0);
    compare_model("mid restart");

    // Timeout on the narrow-counter instance
    start_scn();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 100; i++) tick8(i < 30);
    repeat (300) tick8(1'b1);
    check("to count", obs8.size(), 3);
    if (obs8.size() == 3) begin
      check("to duty0",   obs8[0].duty,   76);
      check("to duty",    obs8[2].duty,   255);
      check("to high",    obs8[2].high,   30);
      check("to period",  obs8[2].period, 100);
      check("to lost",    int'(obs8[2].sl), 1);
      check("to latency", obs8[2].cyc - obs8[1].cyc, 246);
    end
    check("to lost held", int'(bus8.signal_lost), 1);
    repeat (5) tick8(1'b0);
    repeat (20) tick8(1'b1);
    check("to lost cleared", int'(bus8.signal_lost), 0);
    check("to no valid on rearm", obs8.size(), 3);
    repeat (10) tick8(1'b1);
    repeat (70) tick8(1'b0);
    tick8(1'b1);
    repeat (20) tick8(1'b0);
    check("to resume count", obs8.size(), 4);
    if (obs8.size() == 4) begin
      check("to resume duty", obs8[3].duty,   76);
      check("to resume lost", int'(obs8[3].sl), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the RGB PWM generator. Samples one PWM waveform, for example a looped-back LED0 channel or an external PWM source.
- Measures high time and period in clock cycles, then computes an 8-bit duty value with a sequential shift-subtract divider.
- Feeds duty readback to the seven-segment path or to self-check logic. Detects loss of signal.

Parameters:
- CNT_W, 16: width of the high-time and period counters. The timeout threshold is 2^CNT_W-1 cycles.
- SYNC_STAGES, 2: number of flops in the input synchronizer. Minimum value is 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high; clears all state
- pwm_in  input  1  asynchronous PWM input
- duty  output  8  last computed duty, floor(high*256/period)
- duty_valid  output  1  one-cycle pulse when duty updates
- high_cnt  output  CNT_W  latched high time of the last complete period
- period_cnt  output  CNT_W  latched period, rising edge to rising edge
- overrun  output  1  sticky: a period completed while the divider was busy
- signal_lost  output  1  no rising edge seen within the timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; synchronizer flops 0.
- Input path: pwm_in passes through SYNC_STAGES flops to give pwm_s. A registered copy pwm_d gives rise = pwm_s & ~pwm_d and fall = ~pwm_s & pwm_d.
- State IDLE: wait for rise, then clear the run counters (period counter loads 1, high counter loads 1) and go to MEASURE. No output is produced on this first edge.
- State MEASURE:
  - The period counter increments every cycle.
  - The high counter increments while pwm_s=1 and freezes on fall.
  - On rise: latch high_cnt and period_cnt, load the divider, restart both run counters at 1, and go to DIVIDE.
- State DIVIDE: 8 iterations, one per cycle.
  - Remainder register is CNT_W+1 bits and is initialised to high.
  - Each iteration: r=r<<1; if r>=period then r=r-period and shift in a quotient bit of 1, else shift in 0.
  - After the 8th iteration, duty takes the quotient and duty_valid pulses for exactly 1 cycle. Return to MEASURE.
  - Latency: duty_valid is high on the 9th clock edge after the edge that registered rise.
- Run counters keep measuring during DIVIDE.
- Overrun: if rise occurs in DIVIDE, the division in progress completes normally. The new period is discarded (counters restart at 1) and overrun is set. overrun clears only on rst_in.
- Arithmetic: high < period always holds, so the quotient is 0..255 with no clamp needed. period=1 cannot occur.
- Timeout:
  - The period counter saturates at 2^CNT_W-1; saturation in MEASURE is the timeout.
  - On timeout: duty=8'hFF if pwm_s=1, else 8'h00. high_cnt and period_cnt are unchanged. duty_valid pulses, signal_lost=1, go to IDLE.
  - Timeout cannot fire in DIVIDE; it is deferred to the return to MEASURE.
- signal_lost clears on the next rise, the same cycle IDLE exits.
- Simultaneous timeout and rise: rise wins, and the measurement uses the saturated count.
- Reset mid-DIVIDE: the division is abandoned and no duty_valid is issued.
- Sustained operation requires a period ≥ 10 cycles; shorter periods produce overrun.

Optional Feature:
- Macro: PWM_DECODE_GLITCH_FILTER_EN.
- Defined: a 3-cycle stability filter follows the synchronizer. pwm_s changes only after the synchronized input has held the new level for 3 consecutive cycles. Pulses of 1-2 cycles are ignored. Edge timing gains 3 cycles of fixed delay, which applies equally to both edges, so measured widths are unchanged.
- Undefined: pwm_s is the raw synchronizer output, with no filter and no added delay.

Test Plan:
- Period 256, high 64, 4 periods -> first edge gives no output; then 3 duty_valid pulses, each with duty=64, high_cnt=64, period_cnt=256.
- Period 200, high 128 -> duty=163, pulse 9 cycles after the registered rise; period 200, high 1 -> duty=1; period 200, high 199 -> duty=254.
- Period 6, high 3, for 3 periods -> overrun=1 and stays 1; every duty_valid emitted shows duty=128.
- With CNT_W=8, hold pwm_in=1 after a valid measurement -> after 255 cycles duty=255, signal_lost=1, duty_valid pulse; a low-then-high restart clears signal_lost with no duty_valid until the following rise.
- Assert rst_in during DIVIDE -> all outputs 0 immediately, no duty_valid; the next measurement needs a fresh first edge.
- With PWM_DECODE_GLITCH_FILTER_EN defined, period 256 / high 64 with 2-cycle low glitches inside the high phase -> duty=64; without the macro, a glitch causes an extra rise that corrupts the measurement.
